tristate_bus_arbiter: RTL and testbench
=======================================

// Module: tristate_bus_arbiter
// PURPOSE
//  N-channel shared tri-state bus driver with round-robin ownership. Each channel
//  requests the bus; exactly one owner drives W-bit bus_out, all others see Z.
//  A mandatory Z turnaround gap separates owners, so two drivers never overlap.
//  Sits between lab peripherals and a common data bus.
// PARAMETERS
//  W          8  bus / per-channel data width
//  N          4  number of requesting channels (>=2)
//  MAX_HOLD   4  max consecutive DRIVE cycles while another channel is waiting (>=1)
//  TURN       1  Z turnaround cycles between owners (>=1)
//  KEEPER     0  1: in IDLE, bus_out holds last driven value instead of Z
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        synchronous reset, active-high
//  req        in   N        req[k]=1: channel k wants the bus
//  data_in    in   N*W      channel k data on data_in[k*W +: W]
//  grant      out  N        one-hot owner, all-zero when nobody drives
//  bus_out    out  W        owner data, else Z (or held value, see KEEPER)
//  bus_busy   out  1        1 while a channel drives (== |grant)
//  owner_id   out  clog2(N) index of current or last owner
// BEHAVIOUR
//  - One clock, synchronous active-high reset as in PORTS.
//  - Reset (incl. mid-transfer): at next edge state=IDLE, grant=0, bus_busy=0,
//    bus_out=Z (also when KEEPER=1), owner_id=N-1, counters=0.
//  - States: IDLE, DRIVE, TURN. grant/owner_id/state registered;
//    bus_out = bus_busy ? data_in[owner_id] : (KEEPER&&IDLE ? held : Z), combinational.
//  - Arbitration: round-robin, search starts at owner_id+1 mod N; after reset ch0 wins first.
//  - IDLE: any req -> DRIVE next cycle with winner (1-cycle req-to-grant latency).
//  - DRIVE: hold_cnt counts DRIVE cycles from 0.
//     req[owner]=0 -> TURN next cycle.
//     hold_cnt==MAX_HOLD-1 and another req pending -> TURN (preemption).
//     no other req pending -> stay, hold_cnt saturates at MAX_HOLD-1.
//  - TURN: grant=0, bus Z for exactly TURN cycles (KEEPER ignored in TURN). On last
//    TURN cycle arbitrate: any req -> DRIVE next cycle, else IDLE.
//  - Preempted owner keeping req high re-enters round-robin; it loses to any other waiting channel.
//  - grant is never multi-hot; grant never changes owner without >=TURN Z cycles between.
//  - KEEPER=1: held value = last bus_out driven in DRIVE; Z again only after reset.
//  - req changes during TURN are sampled only at the arbitration cycle.
// STRUCTURE
//  - tristate_bus_pkg: state encodings (IDLE/DRIVE/TURN) and clog2 function.
//  - Sub-module rr_arbiter #(N): combinational round-robin pick from req and
//    start pointer, outputs one-hot winner + index + any_req.
//  - Top: state register, hold/turn counters, output mux and tri-state assign.
// TESTING  (W=8, N=4, MAX_HOLD=4, TURN=1, KEEPER=0 unless stated)
//  1 rst high 2 cycles, req=0 -> grant=0, bus_out=8'hzz, bus_busy=0, owner_id=3.
//  2 req=4'b0001, ch0=8'hA5, held 3 cycles then dropped -> grant=0001 one cycle after
//    req, bus_out=A5 for 3 cycles, 1 Z cycle, IDLE.
//  3 req=4'b1111 constant -> owners 0,1,2,3,0 each exactly 4 cycles, 1 Z cycle
//    between every pair, grant never multi-hot.
//  4 req=4'b0100 only, held 10 cycles -> ch2 drives all 10 (no preemption), then TURN.
//  5 ch1 driving, rst asserted mid-DRIVE -> next edge grant=0, bus_out=Z; after rst
//    release with req=4'b0010 ch1 granted via ch0-first pointer.
//  6 KEEPER=1, ch3 drives 8'h3C then drops req -> 1 Z cycle, then bus_out=3C held in IDLE.

Source files
------------

// File: rtl/tristate_bus_pkg.sv
// Purpose : shared state encodings and width helper for the tri-state bus arbiter.
// Latency : n/a (types and functions only).
// Backpressure: n/a.
package tristate_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_TURN  = 2'd2
    } bus_state_t;

    // Bits needed to hold 0..value-1, never less than one so counters for
    // degenerate parameter values still have a real register behind them.
    function automatic int clog2(input int value);
        int res;
        int rem;
        res = 0;
        rem = value - 1;
        while (rem > 0) begin
            res = res + 1;
            rem = rem >> 1;
        end
        return (res < 1) ? 1 : res;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purpose : combinational round-robin pick; search begins at start and wraps mod N.
// Latency : zero cycles, purely combinational.
// Backpressure: none; the caller decides when the pick is taken.
//   req        : per-channel requests
//   start      : first index to examine
//   win_onehot : one-hot winner, zero when nobody requests
//   win_idx    : binary index of the winner (0 when nobody requests)
//   any_req    : at least one request present
module rr_arbiter
    import tristate_bus_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  win_onehot,
    output logic [IW-1:0] win_idx,
    output logic          any_req
);

    logic found;
    int   cand;

    always_comb begin
        win_onehot = '0;
        win_idx    = '0;
        any_req    = |req;
        found      = 1'b0;
        cand       = 0;
        for (int i = 0; i < N; i++) begin
            cand = (int'(start) + i) % N;
            if (!found && req[cand]) begin
                found            = 1'b1;
                win_onehot[cand] = 1'b1;
                win_idx          = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Purpose : N-channel shared tri-state bus driver, round-robin ownership with a Z turnaround gap.
// Latency : one cycle from req to grant; bus_out follows data_in of the owner combinationally.
// Backpressure: a waiting channel holds req; the owner is preempted after MAX_HOLD cycles.
//   clk, rst  : clock and synchronous active-high reset
//   req       : per-channel bus request
//   data_in   : channel k data on data_in[k*W +: W]
//   grant     : one-hot owner, all-zero when nobody drives
//   bus_out   : owner data, otherwise Z (or held value in IDLE when KEEPER=1)
//   bus_busy  : a channel is driving (== |grant)
//   owner_id  : index of the current or most recent owner
module tristate_bus_arbiter
    import tristate_bus_pkg::*;
#(
    parameter int W        = 8,
    parameter int N        = 4,
    parameter int MAX_HOLD = 4,
    parameter int TURN     = 1,
    parameter int KEEPER   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          req,
    input  logic [N*W-1:0]        data_in,
    output logic [N-1:0]          grant,
    output wire  [W-1:0]          bus_out,
    output logic                  bus_busy,
    output logic [clog2(N)-1:0]   owner_id
);

    localparam int IW = clog2(N);
    localparam int HW = clog2(MAX_HOLD);
    localparam int TW = clog2(TURN);

    bus_state_t    state, state_nxt;
    logic [N-1:0]  grant_nxt;
    logic [IW-1:0] owner_nxt;
    logic [HW-1:0] hold_cnt, hold_nxt;
    logic [TW-1:0] turn_cnt, turn_nxt;
    logic [W-1:0]  held_dat;
    logic          held_vld;

    logic [IW-1:0] start_ptr;
    logic [N-1:0]  win_onehot;
    logic [IW-1:0] win_idx;
    logic          any_req;
    logic          others_pending;
    logic          hold_last;
    logic [W-1:0]  owner_dat;

    // Round-robin search starts just past the last owner, so that owner is
    // examined last and loses to any other waiting channel.
    assign start_ptr = (owner_id == IW'(N - 1)) ? '0 : owner_id + IW'(1);

    rr_arbiter #(
        .N  (N),
        .IW (IW)
    ) u_rr (
        .req        (req),
        .start      (start_ptr),
        .win_onehot (win_onehot),
        .win_idx    (win_idx),
        .any_req    (any_req)
    );

    // In DRIVE grant is the owner's one-hot, so masking it leaves the waiters.
    assign others_pending = |(req & ~grant);
    assign hold_last      = (hold_cnt == HW'(MAX_HOLD - 1));
    assign owner_dat      = data_in[owner_id*W +: W];

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        owner_nxt = owner_id;
        hold_nxt  = hold_cnt;
        turn_nxt  = turn_cnt;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    state_nxt = ST_DRIVE;
                    grant_nxt = win_onehot;
                    owner_nxt = win_idx;
                    hold_nxt  = '0;
                end
            end
            ST_DRIVE: begin
                if (!req[owner_id] || (hold_last && others_pending)) begin
                    state_nxt = ST_TURN;
                    grant_nxt = '0;
                    turn_nxt  = '0;
                end else if (!hold_last) begin
                    hold_nxt = hold_cnt + HW'(1);
                end
            end
            ST_TURN: begin
                // Requests are only looked at on the final gap cycle.
                if (turn_cnt == TW'(TURN - 1)) begin
                    if (any_req) begin
                        state_nxt = ST_DRIVE;
                        grant_nxt = win_onehot;
                        owner_nxt = win_idx;
                        hold_nxt  = '0;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    turn_nxt = turn_cnt + TW'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            grant    <= '0;
            owner_id <= IW'(N - 1);
            hold_cnt <= '0;
            turn_cnt <= '0;
            held_dat <= '0;
            held_vld <= 1'b0;
        end else begin
            state    <= state_nxt;
            grant    <= grant_nxt;
            owner_id <= owner_nxt;
            hold_cnt <= hold_nxt;
            turn_cnt <= turn_nxt;
            // Remember what was on the bus so a keeper can replay it in IDLE.
            if (state == ST_DRIVE) begin
                held_dat <= owner_dat;
                held_vld <= 1'b1;
            end
        end
    end

    assign bus_busy = |grant;

    // The keeper only acts in IDLE; the turnaround gap is always released.
    assign bus_out = bus_busy ? owner_dat :
                     ((KEEPER != 0) && (state == ST_IDLE) && held_vld) ? held_dat :
                     {W{1'bz}};

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
module tb_tristate_bus_arbiter;

    localparam int W = 8;
    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance, KEEPER=0
    logic          rst;
    logic [N-1:0]  req;
    logic [N*W-1:0] data_in;
    logic [N-1:0]  grant;
    wire  [W-1:0]  bus_out;
    logic          bus_busy;
    logic [1:0]    owner_id;

    // Keeper instance
    logic          rst_k;
    logic [N-1:0]  req_k;
    logic [N*W-1:0] data_k;
    logic [N-1:0]  grant_k;
    wire  [W-1:0]  bus_out_k;
    logic          bus_busy_k;
    logic [1:0]    owner_id_k;

    tristate_bus_arbiter #(.W(W), .N(N), .MAX_HOLD(4), .TURN(1), .KEEPER(0)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .data_in  (data_in),
        .grant    (grant),
        .bus_out  (bus_out),
        .bus_busy (bus_busy),
        .owner_id (owner_id)
    );

    tristate_bus_arbiter #(.W(W), .N(N), .MAX_HOLD(4), .TURN(1), .KEEPER(1)) dut_k (
        .clk      (clk),
        .rst      (rst_k),
        .req      (req_k),
        .data_in  (data_k),
        .grant    (grant_k),
        .bus_out  (bus_out_k),
        .bus_busy (bus_busy_k),
        .owner_id (owner_id_k)
    );

    typedef struct packed {
        logic       rst;
        logic [3:0] req;
        logic [3:0] exp_grant;
        logic [1:0] exp_owner;
    } vec_t;

    typedef struct packed {
        logic [3:0] grant;
        logic [1:0] owner;
        logic       bus_eq;   // 1: bus_out must equal bus; 0: must differ
        logic [7:0] bus;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    logic [N*W-1:0] data_main;

    function automatic logic [7:0] byte_of(input logic [N*W-1:0] d, input int k);
        return d[k*8 +: 8];
    endfunction

    task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] g, input logic [1:0] o);
        vec_t v;
        v.rst = r; v.req = rq; v.exp_grant = g; v.exp_owner = o;
        tbl.push_back(v);
    endtask

    task automatic add_n(input int n, input logic r, input logic [3:0] rq,
                         input logic [3:0] g, input logic [1:0] o);
        for (int i = 0; i < n; i++) add(r, rq, g, o);
    endtask

    task automatic push_exp(input logic [3:0] g, input logic [1:0] o, input logic eq, input logic [7:0] b);
        exp_t e;
        e.grant = g; e.owner = o; e.bus_eq = eq; e.bus = b;
        sb.push_back(e);
    endtask

    task automatic cmp(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic check_out(input string nm, input int idx, input logic [3:0] g,
                             input logic [1:0] o, input logic b, input logic [7:0] bo);
        exp_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s[%0d]: scoreboard empty", nm, idx);
            return;
        end
        e = sb.pop_front();
        cmp({nm, ".grant"}, idx, {4'b0, g}, {4'b0, e.grant});
        cmp({nm, ".owner_id"}, idx, {6'b0, o}, {6'b0, e.owner});
        cmp({nm, ".bus_busy"}, idx, {7'b0, b}, {7'b0, |e.grant});
        n_vec++;
        if (e.bus_eq ? (bo !== e.bus) : (bo === e.bus)) begin
            n_miss++;
            $display("FAIL %s.bus_out[%0d]: got %h required %s %h", nm, idx, bo,
                     e.bus_eq ? "==" : "!=", e.bus);
        end
    endtask

    // Grant must never be multi-hot on either instance.
    always @(negedge clk) begin
        if ($countones(grant) > 1 || $countones(grant_k) > 1) begin
            n_miss++;
            $display("FAIL onehot: grant %b grant_k %b required at most one bit", grant, grant_k);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        data_main = {8'h3D, 8'hC2, 8'h5B, 8'hA5};
        rst = 1'b1; req = '0; data_in = data_main;
        rst_k = 1'b1; req_k = '0; data_k = {8'h3C, 8'h11, 8'h22, 8'h33};

        // Reset, including reset winning over requests
        add_n(2, 1, 4'b0000, 4'b0000, 2'd3);
        add(1, 4'b1111, 4'b0000, 2'd3);
        // ch0 alone for 3 cycles, then TURN, then IDLE
        add_n(3, 0, 4'b0001, 4'b0001, 2'd0);
        add_n(3, 0, 4'b0000, 4'b0000, 2'd0);
        // All requesting from reset: 0,1,2,3,0 with 4-cycle holds and 1 Z gap
        add(1, 4'b0000, 4'b0000, 2'd3);
        add_n(4, 0, 4'b1111, 4'b0001, 2'd0);
        add(0, 4'b1111, 4'b0000, 2'd0);
        add_n(4, 0, 4'b1111, 4'b0010, 2'd1);
        add(0, 4'b1111, 4'b0000, 2'd1);
        add_n(4, 0, 4'b1111, 4'b0100, 2'd2);
        add(0, 4'b1111, 4'b0000, 2'd2);
        add_n(4, 0, 4'b1111, 4'b1000, 2'd3);
        add(0, 4'b1111, 4'b0000, 2'd3);
        add_n(4, 0, 4'b1111, 4'b0001, 2'd0);
        add_n(2, 0, 4'b0000, 4'b0000, 2'd0);
        // ch2 alone for 10 cycles: no preemption
        add_n(10, 0, 4'b0100, 4'b0100, 2'd2);
        add_n(2, 0, 4'b0000, 4'b0000, 2'd2);
        // ch0 and ch2 alternate; pointer starts after ch2 so ch0 goes first
        add_n(4, 0, 4'b0101, 4'b0001, 2'd0);
        add(0, 4'b0101, 4'b0000, 2'd0);
        add_n(4, 0, 4'b0101, 4'b0100, 2'd2);
        add(0, 4'b0101, 4'b0000, 2'd2);
        add_n(4, 0, 4'b0101, 4'b0001, 2'd0);
        add_n(2, 0, 4'b0000, 4'b0000, 2'd0);
        // ch3 alone saturates its hold; a late ch1 request preempts at once
        add_n(6, 0, 4'b1000, 4'b1000, 2'd3);
        add(0, 4'b1010, 4'b0000, 2'd3);
        add(0, 4'b1010, 4'b0010, 2'd1);
        add(0, 4'b0010, 4'b0010, 2'd1);
        add_n(2, 0, 4'b0000, 4'b0000, 2'd1);
        // Reset in the middle of a ch1 transfer, then ch1 again via ch0-first pointer
        add_n(2, 0, 4'b0010, 4'b0010, 2'd1);
        add(1, 4'b0010, 4'b0000, 2'd3);
        add(0, 4'b0010, 4'b0010, 2'd1);
        add_n(2, 0, 4'b0000, 4'b0000, 2'd1);

        foreach (tbl[i]) begin
            rst = tbl[i].rst;
            req = tbl[i].req;
            // Driven: bus equals owner data. Released: must not show that data.
            push_exp(tbl[i].exp_grant, tbl[i].exp_owner, |tbl[i].exp_grant,
                     byte_of(data_main, int'(tbl[i].exp_owner)));
            @(posedge clk);
            #1;
            check_out("main", i, grant, owner_id, bus_busy, bus_out);
        end

        // KEEPER=1 sequence: ch3 drives 3C, gap releases, IDLE holds 3C
        rst_k = 1'b1; req_k = '0;
        push_exp(4'b0000, 2'd3, 1'b0, 8'h3C);
        @(posedge clk); #1; check_out("keep_rst", 0, grant_k, owner_id_k, bus_busy_k, bus_out_k);
        push_exp(4'b0000, 2'd3, 1'b0, 8'h3C);
        @(posedge clk); #1; check_out("keep_rst", 1, grant_k, owner_id_k, bus_busy_k, bus_out_k);
        rst_k = 1'b0; req_k = 4'b1000;
        push_exp(4'b1000, 2'd3, 1'b1, 8'h3C);
        @(posedge clk); #1; check_out("keep_drv", 0, grant_k, owner_id_k, bus_busy_k, bus_out_k);
        req_k = 4'b0000;
        push_exp(4'b0000, 2'd3, 1'b0, 8'h3C);
        @(posedge clk); #1; check_out("keep_turn", 0, grant_k, owner_id_k, bus_busy_k, bus_out_k);
        push_exp(4'b0000, 2'd3, 1'b1, 8'h3C);
        @(posedge clk); #1; check_out("keep_idle", 0, grant_k, owner_id_k, bus_busy_k, bus_out_k);
        // Live data changing in IDLE must not leak onto the held bus
        data_k = {8'h00, 8'h11, 8'h22, 8'h33};
        push_exp(4'b0000, 2'd3, 1'b1, 8'h3C);
        @(posedge clk); #1; check_out("keep_idle", 1, grant_k, owner_id_k, bus_busy_k, bus_out_k);
        rst_k = 1'b1;
        push_exp(4'b0000, 2'd3, 1'b0, 8'h3C);
        @(posedge clk); #1; check_out("keep_rst2", 0, grant_k, owner_id_k, bus_busy_k, bus_out_k);

        if (sb.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL scoreboard: %0d entries left, required 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
